// File: rtl/shiftrows_colbuf.sv
// Column-serial AES ShiftRows buffer feeding the mixcolumns datapath.
// Optional SHIFTROWS_INV_EN adds an inv port for InvShiftRows.
module shiftrows_colbuf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_col,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_col,
  output logic        out_first,
`ifdef SHIFTROWS_INV_EN
  input  logic        inv,
`endif
  output logic        out_last
);

  typedef enum logic {
    FILL,
    DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  in_cnt_q, in_cnt_d;
  logic [1:0]  out_cnt_q, out_cnt_d;
  logic [31:0] mem [4];
  logic        inv_q;
  logic        acc, done;

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == DRAIN);
  assign out_first = out_valid & (out_cnt_q == 2'd0);
  assign out_last  = out_valid & (out_cnt_q == 2'd3);

  // clr wins over both handshakes in the same cycle
  assign acc  = in_valid & in_ready & ~clr;
  assign done = out_valid & out_ready & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      in_cnt_q  <= 2'd0;
      out_cnt_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    if (clr) begin
      state_d   = FILL;
      in_cnt_d  = 2'd0;
      out_cnt_d = 2'd0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (acc) begin
            in_cnt_d = in_cnt_q + 2'd1;
            if (in_cnt_q == 2'd3)
              state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (done) begin
            out_cnt_d = out_cnt_q + 2'd1;
            if (out_cnt_q == 2'd3)
              state_d = FILL;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  // data storage is never reset or cleared
  always_ff @(posedge clk) begin
    if (acc)
      mem[in_cnt_q] <= in_col;
  end

`ifdef SHIFTROWS_INV_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      inv_q <= 1'b0;
    else if (acc && in_cnt_q == 2'd0)
      inv_q <= inv;
  end
`else
  assign inv_q = 1'b0;
`endif

  always_comb begin
    logic [1:0] sel;
    sel     = 2'd0;
    out_col = '0;
    for (int r = 0; r < 4; r++) begin
      sel = inv_q ? out_cnt_q - 2'(r)
                  : out_cnt_q + 2'(r);
      out_col[8*r +: 8] = mem[sel][8*r +: 8];
    end
  end

endmodule

// File: tb/tb_shiftrows_colbuf.sv
// Directed testbench for shiftrows_colbuf.
// Uses FIPS-197 round-1 SubBytes vectors.
module tb_shiftrows_colbuf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_col = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_col;
  logic        out_first;
  logic        out_last;
  logic        inv = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] fwd_in [4];
  logic [31:0] fwd_out [4];
  logic [31:0] b2b_out [4];
  bit          pat [4];

  always #5 clk = ~clk;

  shiftrows_colbuf dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_col    (in_col),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_col   (out_col),
    .out_first (out_first),
`ifdef SHIFTROWS_INV_EN
    .inv       (inv),
`endif
    .out_last  (out_last)
  );

  task automatic send_state(input bit use_out);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_col   = use_out ? fwd_out[i] : fwd_in[i];
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL fill_ready beat %0d: got %b want 1", i, in_ready);
      end
    end
  endtask

  task automatic run_drain(input bit want_in, input bit stall);
    int          k;
    bit          held_v;
    logic [31:0] held;
    logic [31:0] e;
    k      = 0;
    held_v = 1'b0;
    held   = '0;
    for (int cyc = 0; cyc < 40 && k < 4; cyc++) begin
      @(negedge clk);
      in_valid  = stall;
      in_col    = 32'hdeadbeef;
      out_ready = stall ? pat[cyc % 4] : 1'b1;
      #1;
      e = want_in ? fwd_in[k] : fwd_out[k];
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL drain_state: valid=%b ready=%b want 1/0",
                 out_valid, in_ready);
      end
      if (held_v) begin
        checks++;
        if (out_col !== held) begin
          errors++;
          $display("FAIL stall_hold: got %h want %h", out_col, held);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (out_col !== e || out_first !== (k == 0) ||
            out_last !== (k == 3)) begin
          errors++;
          $display("FAIL drain_beat %0d: got %h f%b l%b want %h f%b l%b",
                   k, out_col, out_first, out_last, e, k == 0, k == 3);
        end
        k++;
        held_v = 1'b0;
      end else if (out_valid) begin
        held   = out_col;
        held_v = 1'b1;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (k != 4) begin
      errors++;
      $display("FAIL drain_timeout: got %0d beats want 4", k);
    end
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_drain: ready=%b valid=%b want 1/0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        out_first !== 1'b0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b f=%b l=%b want 1 0 0 0",
               in_ready, out_valid, out_first, out_last);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    send_state(1'b0);
    run_drain(1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    send_state(1'b0);
    run_drain(1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] q [8];
    int          acc_cyc [8];
    int          idx, nout, last_cyc;
    logic [31:0] e;
    for (int i = 0; i < 4; i++) begin
      q[i]     = fwd_in[i];
      q[i + 4] = fwd_out[i];
    end
    idx      = 0;
    nout     = 0;
    last_cyc = -1;
    for (int cyc = 0; cyc < 60 && nout < 8; cyc++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_col    = q[idx < 8 ? idx : 7];
      out_ready = 1'b1;
      #1;
      if (in_ready && idx < 8) begin
        acc_cyc[idx] = cyc;
        idx++;
      end
      if (out_valid) begin
        e = nout < 4 ? fwd_out[nout] : b2b_out[nout - 4];
        checks++;
        if (out_col !== e) begin
          errors++;
          $display("FAIL b2b_beat %0d: got %h want %h", nout, out_col, e);
        end
        if (nout == 3)
          last_cyc = cyc;
        nout++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (nout != 8 || idx != 8) begin
      errors++;
      $display("FAIL b2b_timeout: got %0d out %0d in want 8 8", nout, idx);
    end else begin
      checks++;
      if (acc_cyc[4] != last_cyc + 1) begin
        errors++;
        $display("FAIL b2b_gap: got cycle %0d want %0d",
                 acc_cyc[4], last_cyc + 1);
      end
      checks++;
      if (acc_cyc[3] - acc_cyc[0] != 3) begin
        errors++;
        $display("FAIL fill_4cyc: got %0d want 3", acc_cyc[3] - acc_cyc[0]);
      end
    end
  endtask

  task automatic test_clr_fill();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_col   = 32'h11111111 * (i + 1);
    end
    @(negedge clk);
    clr      = 1'b1;
    in_col   = 32'h33333333;
    @(negedge clk);
    clr      = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_fill: rdy=%b vld=%b want 1/0", in_ready, out_valid);
    end
    send_state(1'b0);
    run_drain(1'b0, 1'b0);
  endtask

  task automatic test_clr_drain();
    send_state(1'b0);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_col !== fwd_out[0]) begin
      errors++;
      $display("FAIL clr_drain_beat0: got %b %h want 1 %h",
               out_valid, out_col, fwd_out[0]);
    end
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL clr_drain_idle %0d: vld=%b rdy=%b want 0/1",
                 i, out_valid, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    send_state(1'b0);
    run_drain(1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    send_state(1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre: vld=%b want 1", out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_first !== 1'b0) begin
      errors++;
      $display("FAIL arst_now: vld=%b rdy=%b f=%b want 0 1 0",
               out_valid, in_ready, out_first);
    end
    #1;
    rst_n = 1'b1;
    send_state(1'b0);
    run_drain(1'b0, 1'b0);
  endtask

`ifdef SHIFTROWS_INV_EN
  task automatic test_inv();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_col   = fwd_out[i];
      inv      = (i == 0);
    end
    run_drain(1'b1, 1'b0);
    inv = 1'b0;
  endtask
`endif

  initial begin
    fwd_in[0]  = 32'hae1127d4;
    fwd_in[1]  = 32'hf198bfe0;
    fwd_in[2]  = 32'he55db4b8;
    fwd_in[3]  = 32'h3052411e;
    fwd_out[0] = 32'h305dbfd4;
    fwd_out[1] = 32'hae52b4e0;
    fwd_out[2] = 32'hf11141b8;
    fwd_out[3] = 32'he598271e;
    b2b_out[0] = 32'he511b4d4;
    b2b_out[1] = 32'h309841e0;
    b2b_out[2] = 32'hae5d27b8;
    b2b_out[3] = 32'hf152bf1e;
    pat[0] = 1'b1;
    pat[1] = 1'b0;
    pat[2] = 1'b0;
    pat[3] = 1'b1;

    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_clr_fill();
    test_clr_drain();
    test_async_reset();
`ifdef SHIFTROWS_INV_EN
    test_inv();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
